// File: rtl/bus_master_if.sv
// Per-master shared-bus interface: turns a hold-until-ack local request into a
// request/grant/strobe/ready bus access, with a watchdog for unanswered accesses.
module bus_master_if #(
    parameter int unsigned ADDR_W  = 30,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic              cpu_busy,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_
);

    localparam bit            WD_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] WD_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t          state;
    logic [TO_W-1:0] wd_cnt;

    // Single registered FSM; ack/err and the strobe default to inactive each cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bus_req_    <= 1'b1;
            bus_as_     <= 1'b1;
            bus_rw      <= 1'b1;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            cpu_rd_data <= '0;
            cpu_ack     <= 1'b0;
            cpu_err     <= 1'b0;
            cpu_busy    <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            cpu_ack <= 1'b0;
            cpu_err <= 1'b0;
            bus_as_ <= 1'b1;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        bus_rw      <= cpu_rw;
                        bus_addr    <= cpu_addr;
                        bus_wr_data <= cpu_wr_data;
                        bus_req_    <= 1'b0;
                        cpu_busy    <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (!bus_grnt_) begin
                        bus_as_ <= 1'b0;
                        wd_cnt  <= '0;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Slave ready takes priority over a coincident watchdog expiry.
                    if (!bus_rdy_) begin
                        if (bus_rw) begin
                            cpu_rd_data <= bus_rd_data;
                        end
                        cpu_ack  <= 1'b1;
                        cpu_busy <= 1'b0;
                        bus_req_ <= 1'b1;
                        bus_rw   <= 1'b1;
                        state    <= IDLE;
                    end else if (WD_EN && (wd_cnt == WD_LAST)) begin
                        cpu_ack     <= 1'b1;
                        cpu_err     <= 1'b1;
                        cpu_rd_data <= '0;
                        cpu_busy    <= 1'b0;
                        bus_req_    <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + TO_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus_req_ <= 1'b1;
                    cpu_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bus_master_if.md
Name: bus_master_if

Overview:
- Per-master bus interface that sits directly upstream of the round-robin bus arbiter.
- Converts a simple hold-until-ack request from a local requester (CPU fetch/data port, DMA) into the shared-bus protocol:
  - raises the active-low bus request and waits for the active-low grant;
  - issues one address-strobed access;
  - waits for the slave's active-low ready, then returns read data and an ack pulse.
- Holds its bus request through the whole access so the arbiter keeps ownership stable; releases it on completion.
- Includes a watchdog that aborts accesses no slave answers.

Parameters:
- ADDR_W, 30, word address width
- DATA_W, 32, data width
- TIMEOUT, 16, max cycles in ACCESS before abort; 0 disables the watchdog
- TO_W, 8, watchdog counter width; must satisfy TIMEOUT < 2^TO_W

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cpu_req  in  1  requester access request, active-high; held until cpu_ack
- cpu_rw  in  1  1=read, 0=write
- cpu_addr  in  ADDR_W  access address
- cpu_wr_data  in  DATA_W  write data
- cpu_rd_data  out  DATA_W  read data, registered, valid while cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  qualifies cpu_ack: 1 = timeout abort
- cpu_busy  out  1  high from request acceptance through the cycle before cpu_ack
- bus_req_  out  1  bus request to arbiter, active-low
- bus_grnt_  in  1  grant from arbiter, active-low
- bus_as_  out  1  address strobe, active-low
- bus_rw  out  1  1=read, 0=write
- bus_addr  out  ADDR_W  bus address
- bus_wr_data  out  DATA_W  bus write data
- bus_rd_data  in  DATA_W  slave read data, valid when bus_rdy_=0
- bus_rdy_  in  1  slave ready, active-low

Behaviour:
- All outputs are registered. Reset values:
  - state=IDLE
  - bus_req_=1, bus_as_=1, bus_rw=1
  - bus_addr=0, bus_wr_data=0
  - cpu_rd_data=0, cpu_ack=0, cpu_err=0, cpu_busy=0
  - watchdog counter=0
- IDLE, when cpu_req=1:
  - latch cpu_rw/cpu_addr/cpu_wr_data into bus_rw/bus_addr/bus_wr_data;
  - bus_req_<=0, cpu_busy<=1, go to REQ.
  - Otherwise remain in IDLE.
- REQ:
  - Hold bus_req_=0.
  - When bus_grnt_=0 is sampled: bus_as_<=0 for exactly one cycle, counter<=0, go to ACCESS.
  - REQ is always entered, even if the grant is already parked on this master (minimum one cycle).
- ACCESS:
  - bus_req_ stays 0; bus_as_ returns to 1 after the first ACCESS cycle.
  - bus_addr/bus_rw/bus_wr_data are held stable for the whole access.
  - bus_rdy_=0 may arrive in any ACCESS cycle, including the first (the cycle in which bus_as_=0).
  - On rdy: cpu_rd_data<=bus_rd_data if read; on write, cpu_rd_data is left unchanged.
    - cpu_ack<=1, cpu_err<=0, cpu_busy<=0, bus_req_<=1, bus_rw<=1, go to IDLE.
  - Otherwise counter increments each cycle.
  - If TIMEOUT!=0 and counter==TIMEOUT-1 with bus_rdy_=1: abort.
    - cpu_ack<=1, cpu_err<=1, cpu_rd_data<=0, bus_req_<=1, cpu_busy<=0, go to IDLE.
  - If rdy and timeout coincide, rdy wins: normal completion, err=0.
- Ack and back-to-back:
  - cpu_ack/cpu_err are high for one cycle only.
  - The requester must deassert cpu_req during the ack cycle unless issuing the next access.
  - cpu_req=1 sampled in the ack cycle starts a new transaction: bus_req_ goes 0 again on the following edge, giving one bus_req_=1 cycle between accesses so the arbiter can rotate ownership.
- Requester inputs are ignored outside IDLE.
- bus_rdy_ and bus_grnt_ are ignored in IDLE; bus_rdy_ is also ignored in REQ.
- Latency, grant already present: accept edge → REQ; next edge → ACCESS with as_=0. With a single-cycle slave, cpu_ack is high 3 cycles after cpu_req is first sampled.
- Reset mid-operation:
  - Any state returns to IDLE with reset values on the next edge.
  - bus_req_ releases immediately.
  - No ack is produced for the aborted access.

Test Plan:
- Read, grant parked, single-cycle slave:
  - Stimulus: cpu_req=1, rw=1, addr=0x0000100; grnt_=0; rdy_=0 with rd_data=0xDEADBEEF in the first ACCESS cycle.
  - Response: as_ low exactly one cycle with bus_addr=0x0000100; cpu_ack one cycle with rd_data=0xDEADBEEF, err=0; bus_req_=1 after.
- Write with grant delayed 5 cycles, slave ready on 3rd ACCESS cycle:
  - Stimulus: addr=0x3FFFFFF, wr_data=0x12345678.
  - Response: bus_req_=0 for 5 REQ cycles plus 3 ACCESS cycles; bus_wr_data stable throughout; single ack, err=0; cpu_rd_data unchanged.
- Timeout (TIMEOUT=16, rdy_ held 1):
  - Response: exactly 16 ACCESS cycles; ack with err=1 and rd_data=0; bus_req_ released; busy=0.
- Back-to-back reads with cpu_req held through the ack:
  - Response: two transactions; one bus_req_=1 gap cycle between them; two ack pulses; second address correct.
- Reset during ACCESS:
  - Stimulus: reset=1 for 1 cycle while in ACCESS.
  - Response: next cycle bus_req_=1, as_=1, ack=0, busy=0; a subsequent request completes normally.
- rdy_=0 on the same cycle the counter hits TIMEOUT-1:
  - Response: ack with err=0 and the bus_rd_data value captured.
